// File: rtl/axi_pkg.sv
// Shared AXI encodings: burst types, response codes and the read-slave state set.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } slv_state_e;

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int AddrW = 32
) (
    input  logic [AddrW-1:0] addr_i,
    input  logic [1:0]       size_i,
    input  logic [3:0]       len_i,
    input  logic [1:0]       burst_i,
    output logic [AddrW-1:0] next_addr_o
);

    logic [AddrW-1:0] incr;
    logic [AddrW-1:0] container;
    logic [AddrW-1:0] mask;

    always_comb begin
        incr      = AddrW'(1) << size_i;
        container = ({{(AddrW-4){1'b0}}, len_i} + AddrW'(1)) << size_i;
        mask      = container - AddrW'(1);
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = addr_i + incr;
            // addr never leaves its container, so its upper bits are the wrap base
            BURST_WRAP:  next_addr_o = (addr_i & ~mask) | ((addr_i + incr) & mask);
            default:     next_addr_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_read_slave.sv
// Memory-backed AXI read slave: one AR at a time, registered R channel,
// backdoor write port for preloading the word array.
module axi_read_slave
    import axi_pkg::*;
#(
    parameter int BusWidth = 32,
    parameter int TagBits  = 4,
    parameter int MemWords = 256
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [TagBits-1:0]          ARID,
    input  logic [BusWidth-1:0]         ARADDR,
    input  logic [3:0]                  ARLEN,
    input  logic [1:0]                  ARSIZE,
    input  logic [1:0]                  ARBURST,
    input  logic [1:0]                  ARLOCK,
    input  logic [3:0]                  ARCACHE,
    input  logic [2:0]                  ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [TagBits-1:0]          RID,
    output logic [BusWidth-1:0]         RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY,
    input  logic                        mem_we,
    input  logic [$clog2(MemWords)-1:0] mem_waddr,
    input  logic [BusWidth-1:0]         mem_wdata
);

    localparam int LaneBits = $clog2(BusWidth / 8);
    localparam int IdxBits  = $clog2(MemWords);
    localparam logic [1:0] MaxSize = 2'(LaneBits);

    slv_state_e state_q, state_d;
    logic [TagBits-1:0]  id_q, id_d, rid_q, rid_d;
    logic [BusWidth-1:0] addr_q, addr_d, rdata_q, rdata_d;
    logic [3:0]          len_q, len_d, beat_q, beat_d;
    logic [1:0]          size_q, size_d, burst_q, burst_d, rresp_q, rresp_d;
    logic                err_q, err_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic                arready_q, arready_d;

    logic [BusWidth-1:0] mem_q [MemWords];
    logic [BusWidth-1:0] next_addr, beat_addr, beat_data;
    logic [IdxBits-1:0]  word_idx;
    logic                word_oob, beat_err, ar_slverr;
    resp_e               beat_resp;
    logic                unused_ar_attrs;

    assign unused_ar_attrs = ^{ARLOCK, ARCACHE, ARPROT};

    always_ff @(posedge ACLK) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    axi_addr_gen #(.AddrW(BusWidth)) u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    assign ar_slverr = (ARBURST == BURST_RSVD)
                    || ((ARBURST == BURST_WRAP) && !(ARLEN inside {4'd1, 4'd3, 4'd7, 4'd15}))
                    || (ARSIZE > MaxSize);

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        beat_d    = beat_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        beat_data = '0;
        beat_resp = RESP_OKAY;

        // in IDLE the beat being launched is the first one of the incoming AR
        beat_addr = next_addr;
        beat_err  = err_q;
        if (state_q == ST_IDLE) begin
            beat_addr = ARADDR;
            beat_err  = ar_slverr;
        end
        word_idx = beat_addr[LaneBits +: IdxBits];
        word_oob = |(beat_addr >> (LaneBits + IdxBits));
        if (beat_err) begin
            beat_resp = RESP_SLVERR;
        end else if (word_oob) begin
            beat_resp = RESP_DECERR;
        end else begin
            beat_data = mem_q[word_idx];
        end

        case (state_q)
            ST_IDLE: begin
                if (ARVALID && arready_q) begin
                    state_d  = ST_BURST;
                    id_d     = ARID;
                    addr_d   = ARADDR;
                    len_d    = ARLEN;
                    size_d   = ARSIZE;
                    burst_d  = ARBURST;
                    err_d    = ar_slverr;
                    beat_d   = 4'd0;
                    rvalid_d = 1'b1;
                    rid_d    = ARID;
                    rdata_d  = beat_data;
                    rresp_d  = beat_resp;
                    rlast_d  = (ARLEN == 4'd0);
                end
            end
            ST_BURST: begin
                if (RREADY) begin
                    if (rlast_q) begin
                        state_d  = ST_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        addr_d  = next_addr;
                        rdata_d = beat_data;
                        rresp_d = beat_resp;
                        rlast_d = ((beat_q + 4'd1) == len_q);
                    end
                end
            end
        endcase

        arready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            beat_q    <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rid_q     <= '0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            arready_q <= arready_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RID     = rid_q;

endmodule
